// File: rtl/perimeter_arbiter.sv
// perimeter_arbiter: shares one z = 2*(base+height) datapath between two producer
// channels using /dav-rfd handshakes, with round-robin tie breaking.
// Ports:
//   clock, reset              - system clock; synchronous active-high reset
//   base_x, height_x          - channel x operands (W bits), sampled at the grant edge
//   dav_in_x_ / rfd_in_x      - channel x data-valid (active low) / ready-for-data
//   data_out, tag_out         - registered perimeter (W+2 bits) and source channel (0=ch1, 1=ch2)
//   dav_out_ / rfd_out        - result valid (active low) / consumer ready-for-data
// Optional: define PERIMETER_ARB_STATS_EN to add served_1/served_2 16-bit grant counters.
module perimeter_arbiter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] base_1,
    input  logic [W-1:0] height_1,
    input  logic         dav_in_1_,
    output logic         rfd_in_1,
    input  logic [W-1:0] base_2,
    input  logic [W-1:0] height_2,
    input  logic         dav_in_2_,
    output logic         rfd_in_2,
    output logic [W+1:0] data_out,
    output logic         tag_out,
    output logic         dav_out_,
    input  logic         rfd_out
`ifdef PERIMETER_ARB_STATS_EN
    ,
    output logic [15:0]  served_1,
    output logic [15:0]  served_2
`endif
);
    localparam int unsigned SW = W + 1;
    localparam int unsigned RW = W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REL  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;      // channel of the most recent grant; also the active grant
    logic          rfd_1_q, rfd_1_d;
    logic          rfd_2_q, rfd_2_d;
    logic [RW-1:0] data_q, data_d;
    logic          tag_q, tag_d;
    logic          dav_out_q, dav_out_d;

    logic          req_1, req_2, pick_2, grant, gnt_dav_;
    logic [SW-1:0] sum_1, sum_2;

    // Requests are the dav_ levels seen at the sampling edge only.
    assign req_1    = ~dav_in_1_;
    assign req_2    = ~dav_in_2_;
    assign pick_2   = (req_1 & req_2) ? ~last_q : req_2;
    assign grant    = (state_q == S_IDLE) && (req_1 || req_2);
    assign gnt_dav_ = last_q ? dav_in_2_ : dav_in_1_;

    // Full-width sums; the doubling is a wire shift so nothing is truncated.
    assign sum_1 = SW'(base_1) + SW'(height_1);
    assign sum_2 = SW'(base_2) + SW'(height_2);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        rfd_1_d   = rfd_1_q;
        rfd_2_d   = rfd_2_q;
        data_d    = data_q;
        tag_d     = tag_q;
        dav_out_d = dav_out_q;
        case (state_q)
            S_IDLE: begin
                rfd_1_d   = 1'b1;
                rfd_2_d   = 1'b1;
                dav_out_d = 1'b1;
                if (grant) begin
                    last_d  = pick_2;
                    tag_d   = pick_2;
                    data_d  = pick_2 ? {sum_2, 1'b0} : {sum_1, 1'b0};
                    if (pick_2) begin
                        rfd_2_d = 1'b0;
                    end else begin
                        rfd_1_d = 1'b0;
                    end
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (gnt_dav_) begin
                    if (last_q) begin
                        rfd_2_d = 1'b1;
                    end else begin
                        rfd_1_d = 1'b1;
                    end
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (rfd_out) begin
                    dav_out_d = 1'b0;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (!rfd_out) begin
                    dav_out_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            rfd_1_q   <= 1'b1;
            rfd_2_q   <= 1'b1;
            data_q    <= '0;
            tag_q     <= 1'b0;
            dav_out_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rfd_1_q   <= rfd_1_d;
            rfd_2_q   <= rfd_2_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            dav_out_q <= dav_out_d;
        end
    end

    assign rfd_in_1 = rfd_1_q;
    assign rfd_in_2 = rfd_2_q;
    assign data_out = data_q;
    assign tag_out  = tag_q;
    assign dav_out_ = dav_out_q;

`ifdef PERIMETER_ARB_STATS_EN
    logic [15:0] cnt_1_q, cnt_1_d;
    logic [15:0] cnt_2_q, cnt_2_d;

    // Per-channel grant counters, wrapping naturally at 16 bits.
    always_comb begin
        cnt_1_d = cnt_1_q;
        cnt_2_d = cnt_2_q;
        if (grant && !pick_2) cnt_1_d = cnt_1_q + 16'd1;
        if (grant && pick_2)  cnt_2_d = cnt_2_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_1_q <= '0;
            cnt_2_q <= '0;
        end else begin
            cnt_1_q <= cnt_1_d;
            cnt_2_q <= cnt_2_d;
        end
    end

    assign served_1 = cnt_1_q;
    assign served_2 = cnt_2_q;
`endif
endmodule

// File: tb/tb_perimeter_arbiter.sv
// tb_perimeter_arbiter: transaction-level model of the arbiter compared every cycle,
// driven by behavioural producers/consumer with directed and randomized traffic.
module tb_perimeter_arbiter;
    localparam int unsigned W = 8;

    logic         clock     = 1'b0;
    logic         reset     = 1'b1;
    logic [W-1:0] base_1    = '0;
    logic [W-1:0] height_1  = '0;
    logic [W-1:0] base_2    = '0;
    logic [W-1:0] height_2  = '0;
    logic         dav_in_1_ = 1'b1;
    logic         dav_in_2_ = 1'b1;
    logic         rfd_out   = 1'b1;
    logic         rfd_in_1, rfd_in_2;
    logic [W+1:0] data_out;
    logic         tag_out, dav_out_;
`ifdef PERIMETER_ARB_STATS_EN
    logic [15:0]  served_1, served_2;
`endif

    perimeter_arbiter #(.W(W)) dut (
        .clock(clock), .reset(reset),
        .base_1(base_1), .height_1(height_1), .dav_in_1_(dav_in_1_), .rfd_in_1(rfd_in_1),
        .base_2(base_2), .height_2(height_2), .dav_in_2_(dav_in_2_), .rfd_in_2(rfd_in_2),
        .data_out(data_out), .tag_out(tag_out), .dav_out_(dav_out_), .rfd_out(rfd_out)
`ifdef PERIMETER_ARB_STATS_EN
        , .served_1(served_1), .served_2(served_2)
`endif
    );

    always #5 clock = ~clock;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // Traffic shaping knobs (delays in cycles, picked uniformly in [lo,hi]).
    int rel_lo = 0, rel_hi = 0, ack_lo = 0, ack_hi = 0;
    int rdy_lo = 0, rdy_hi = 0, gap_lo = 0, gap_hi = 0;
    bit glitch_en = 1'b0;
    int rst_cnt   = 3;

    logic [15:0] q_1[$];
    logic [15:0] q_2[$];

    bit p_act[2];
    bit p_gnt[2];
    int p_cnt[2];
    int p_gap[2];

    bit          c_cap  = 1'b0;
    int          c_cnt  = 0;
    int          c_rise = 0;
    int          ncap   = 0;
    logic [10:0] log_res[$];
    int          log_lat[$];
    int          log_rise[$];

    // Transaction-level view: is a transfer in flight, has its producer let go,
    // has the result been offered, and the round-robin memory.
    bit          m_busy = 0, m_rel = 0, m_shown = 0, m_last = 1, m_tag = 0;
    bit          m_rfd1 = 1, m_rfd2 = 1, m_dav = 1;
    logic [9:0]  m_data = '0;
    int          m_gnt_cyc = 0;
    logic [15:0] m_srv1 = '0, m_srv2 = '0;

    int          snap_cnt = 0;
    logic        snap_dav, snap_r1, snap_r2, snap_tag;
    logic [9:0]  snap_data;
    logic [15:0] snap_s1 = '0, snap_s2 = '0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endfunction

    function automatic int pick(int lo, int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    task automatic set_ops(int c, logic [W-1:0] b, logic [W-1:0] h);
        if (c == 0) begin base_1 = b; height_1 = h; end
        else        begin base_2 = b; height_2 = h; end
    endtask

    task automatic set_dav(int c, logic v);
        if (c == 0) dav_in_1_ = v;
        else        dav_in_2_ = v;
    endtask

    // Apply the rules to the inputs that were present at the edge just passed.
    task automatic model_step();
        bit r1, r2, g;
        logic [W-1:0] b, h;
        r1 = (dav_in_1_ == 1'b0);
        r2 = (dav_in_2_ == 1'b0);
        if (reset) begin
            m_busy = 0; m_last = 1; m_data = '0; m_tag = 0;
            m_rfd1 = 1; m_rfd2 = 1; m_dav = 1; m_srv1 = '0; m_srv2 = '0;
            snap_dav = dav_out_; snap_r1 = rfd_in_1; snap_r2 = rfd_in_2;
            snap_data = data_out; snap_tag = tag_out;
`ifdef PERIMETER_ARB_STATS_EN
            snap_s1 = served_1; snap_s2 = served_2;
`endif
            snap_cnt++;
            c_cap = 1'b0;
            rfd_out = 1'b1;
        end else if (!m_busy) begin
            if (r1 || r2) begin
                g = (r1 && r2) ? !m_last : r2;
                b = g ? base_2 : base_1;
                h = g ? height_2 : height_1;
                m_data = 10'(2 * (int'(b) + int'(h)));
                m_tag = g; m_last = g; m_busy = 1; m_rel = 0; m_shown = 0;
                if (g) begin m_rfd2 = 0; m_srv2 = m_srv2 + 16'd1; end
                else   begin m_rfd1 = 0; m_srv1 = m_srv1 + 16'd1; end
                m_gnt_cyc = cyc;
            end
        end else if (!m_rel) begin
            if ((m_tag ? dav_in_2_ : dav_in_1_) == 1'b1) begin
                m_rel = 1;
                if (m_tag) m_rfd2 = 1; else m_rfd1 = 1;
            end
        end else if (!m_shown) begin
            if (rfd_out) begin m_shown = 1; m_dav = 0; end
        end else if (!rfd_out) begin
            m_dav = 1; m_busy = 0;
        end
    endtask

    task automatic compare();
        chk("rfd_in_1", 32'(rfd_in_1), 32'(m_rfd1));
        chk("rfd_in_2", 32'(rfd_in_2), 32'(m_rfd2));
        chk("dav_out_", 32'(dav_out_), 32'(m_dav));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("tag_out",  32'(tag_out),  32'(m_tag));
`ifdef PERIMETER_ARB_STATS_EN
        chk("served_1", 32'(served_1), 32'(m_srv1));
        chk("served_2", 32'(served_2), 32'(m_srv2));
`endif
    endtask

    task automatic drive_step();
        reset = (rst_cnt > 0);
        if (rst_cnt > 0) rst_cnt--;
        for (int c = 0; c < 2; c++) begin
            logic rf;
            logic [15:0] it;
            rf = (c == 0) ? rfd_in_1 : rfd_in_2;
            if (p_act[c]) begin
                if (rf == 1'b0) p_gnt[c] = 1'b1;
                if (p_gnt[c]) begin
                    // Scramble operands after the grant; the latched result must not move.
                    set_ops(c, W'($urandom), W'($urandom));
                    if (p_cnt[c] == 0) begin
                        set_dav(c, 1'b1);
                        p_act[c] = 1'b0;
                        p_gnt[c] = 1'b0;
                        p_gap[c] = pick(gap_lo, gap_hi);
                    end else begin
                        p_cnt[c]--;
                    end
                end else if (glitch_en) begin
                    set_dav(c, ($urandom_range(3, 0) == 0) ? 1'b1 : 1'b0);
                end
            end else if (p_gap[c] > 0) begin
                p_gap[c]--;
            end else if (rf == 1'b1 && ((c == 0) ? q_1.size() : q_2.size()) > 0) begin
                if (c == 0) it = q_1.pop_front();
                else        it = q_2.pop_front();
                set_ops(c, it[15:8], it[7:0]);
                set_dav(c, 1'b0);
                p_act[c] = 1'b1;
                p_cnt[c] = pick(rel_lo, rel_hi);
            end
        end
        if (rfd_out && !c_cap && dav_out_ == 1'b0) begin
            log_res.push_back({data_out, tag_out});
            log_lat.push_back(cyc - m_gnt_cyc);
            log_rise.push_back(cyc - c_rise);
            ncap++;
            c_cap = 1'b1;
            c_cnt = pick(ack_lo, ack_hi);
        end
        if (c_cap) begin
            if (c_cnt == 0) begin
                rfd_out = 1'b0;
                c_cap = 1'b0;
                c_cnt = pick(rdy_lo, rdy_hi);
            end else begin
                c_cnt--;
            end
        end else if (!rfd_out && dav_out_ == 1'b1) begin
            if (c_cnt == 0) begin
                rfd_out = 1'b1;
                c_rise = cyc;
            end else begin
                c_cnt--;
            end
        end
    endtask

    // Outputs sampled on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            model_step();
            compare();
            drive_step();
        end
    end

    task automatic wait_caps(int n, int limit);
        int k;
        k = 0;
        while (ncap < n && k < limit) begin
            @(negedge clock);
            k++;
        end
        if (ncap < n) begin
            nchk++;
            nerr++;
            $display("FAIL wait_caps timeout: got %0d results, expected %0d", ncap, n);
        end
    endtask

    task automatic do_reset(int n);
        int s, k;
        s = snap_cnt;
        k = 0;
        rst_cnt = n;
        while (snap_cnt < s + n && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("reset_applied", 32'(snap_cnt - s), 32'(n));
        @(negedge clock);
    endtask

    initial begin
        repeat (5) @(negedge clock);
        chk("reset_rfd_in_1", 32'(rfd_in_1), 32'd1);
        chk("reset_dav_out_", 32'(dav_out_), 32'd1);
        chk("reset_data_out", 32'(data_out), 32'd0);

        // Single channel, responsive consumer.
        q_1.push_back({8'd10, 8'd20});
        wait_caps(1, 50);
        chk("t1_result",  32'(log_res[0]), 32'({10'd60, 1'b0}));
        chk("t1_latency", 32'(log_lat[0]), 32'd2);

        // Simultaneous request after reset: ch1 first, then ch2.
        do_reset(2);
        q_1.push_back({8'd3, 8'd4});
        q_2.push_back({8'd100, 8'd200});
        wait_caps(3, 60);
        chk("t2_first",  32'(log_res[1]), 32'({10'd14, 1'b0}));
        chk("t2_second", 32'(log_res[2]), 32'({10'd600, 1'b1}));
`ifdef PERIMETER_ARB_STATS_EN
        chk("t2_served_1", 32'(served_1), 32'd1);
        chk("t2_served_2", 32'(served_2), 32'd1);
`endif

        // Maximum operands.
        q_1.push_back({8'd255, 8'd255});
        wait_caps(4, 50);
        chk("t3_max", 32'(log_res[3]), 32'({10'd1020, 1'b0}));

        // Slow consumer: second result waits with rfd_out low.
        rdy_lo = 5; rdy_hi = 5;
        q_1.push_back({8'd1, 8'd1});
        q_1.push_back({8'd2, 8'd2});
        wait_caps(6, 80);
        chk("t4_first",     32'(log_res[4]),  32'({10'd4, 1'b0}));
        chk("t4_second",    32'(log_res[5]),  32'({10'd8, 1'b0}));
        chk("t4_rise_to_dav", 32'(log_rise[5]), 32'd1);
        rdy_lo = 0; rdy_hi = 0;

        // Reset while the result is being offered.
        ack_lo = 8; ack_hi = 8;
        q_1.push_back({8'd7, 8'd9});
        wait_caps(7, 60);
        chk("t5_pre_dav_out_", 32'(dav_out_), 32'd0);
        do_reset(1);
        chk("t5_dav_out_", 32'(snap_dav),  32'd1);
        chk("t5_rfd_in_1", 32'(snap_r1),   32'd1);
        chk("t5_rfd_in_2", 32'(snap_r2),   32'd1);
        chk("t5_data_out", 32'(snap_data), 32'd0);
        chk("t5_tag_out",  32'(snap_tag),  32'd0);
`ifdef PERIMETER_ARB_STATS_EN
        chk("t5_served_1", 32'(snap_s1), 32'd0);
        chk("t5_served_2", 32'(snap_s2), 32'd0);
`endif
        ack_lo = 0; ack_hi = 0;
        q_1.push_back({8'd1, 8'd2});
        q_2.push_back({8'd3, 8'd4});
        wait_caps(9, 80);
        chk("t5_after_first",  32'(log_res[7]), 32'({10'd6, 1'b0}));
        chk("t5_after_second", 32'(log_res[8]), 32'({10'd14, 1'b1}));

        // Randomized traffic.
        rel_lo = 0; rel_hi = 3; ack_lo = 0; ack_hi = 3;
        rdy_lo = 0; rdy_hi = 3; gap_lo = 0; gap_hi = 4;
        glitch_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            q_1.push_back(16'($urandom));
            q_2.push_back(16'($urandom));
        end
        wait_caps(129, 30000);
        repeat (10) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/perimeter_arbiter.md
Name: perimeter_arbiter

Overview:
- Shares one perimeter datapath (z = 2*(x+y)) between two producer channels, each delivering a (base, height) pair over a /dav-rfd handshake.
- Results go to a single consumer over /dav-rfd, tagged with the originating channel.
- Round-robin arbitration when both producers are pending. Sits between the rectangle-dimension producers and the downstream result consumer.

Parameters:
- W, 8, width of each dimension operand; result width is W+2.

Ports:
- clock  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high reset
- base_1  input  W  channel 1 base
- height_1  input  W  channel 1 height
- dav_in_1_  input  1  channel 1 data valid, active low
- rfd_in_1  output  1  channel 1 ready-for-data
- base_2  input  W  channel 2 base
- height_2  input  W  channel 2 height
- dav_in_2_  input  1  channel 2 data valid, active low
- rfd_in_2  output  1  channel 2 ready-for-data
- data_out  output  W+2  registered perimeter
- tag_out  output  1  registered source channel (0 = ch1, 1 = ch2)
- dav_out_  output  1  result valid, active low
- rfd_out  input  1  consumer ready-for-data

Behaviour:
- Reset (reset==1 at posedge) in any state, including mid-handshake:
  - STAR=S_IDLE, rfd_in_1=1, rfd_in_2=1, dav_out_=1, data_out=0, tag_out=0, LAST=1.
  - The next grant therefore favours ch1.
- Arithmetic: data_out = {base+height, 1'b0}.
  - The W+1-bit sum is never truncated; max for W=8 is 2*510 = 1020.
- Operands are sampled only at the grant edge. Later input changes do not affect data_out.
- States (2-bit STAR) and transitions:
  - S_IDLE: rfd_in_x=1, dav_out_=1.
    - If dav_in_1_==0 and dav_in_2_==0: grant the channel != LAST.
    - Else grant whichever has dav_in_x_==0.
    - On grant: latch data_out and tag_out, drive the granted rfd_in_x<=0, set LAST<=granted, go to S_REL.
    - With no request, hold.
  - S_REL: wait for the granted dav_in_x_==1. Then rfd_in_x<=1 and go to S_OUT.
    - The non-granted rfd stays 1. Its dav_ may fall and stays pending; it is not lost.
  - S_OUT: when rfd_out==1, dav_out_<=0 and go to S_ACK. If rfd_out==0 (consumer still finishing a previous transfer), hold.
  - S_ACK: when rfd_out==0, dav_out_<=1 and go to S_IDLE. data_out and tag_out hold until the next grant.
- One transfer in flight at a time; no new grant is possible before S_IDLE.
- Latency, with an immediately responsive consumer:
  - Grant edge to dav_out_ low takes 2 edges minimum (S_REL one edge, S_OUT one edge).
  - Complete round trip is 4 edges.
- Simultaneous request at reset exit: ch1 is served first, ch2 next.
- Continuous dual requests alternate 1,2,1,2,...
- A single channel requesting repeatedly is served every time; round-robin only breaks ties.
- dav_in_x_ glitching high before the grant is not a request; only the level at the sampling edge counts.

Optional Feature:
- Macro PERIMETER_ARB_STATS_EN.
- Defined:
  - Adds output ports served_1[15:0] and served_2[15:0], reset to 0.
  - The matching counter increments by 1 on each grant edge and wraps from 16'hFFFF to 0.
  - Reset clears both counters in the same cycle.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then ch1 only with base=10, height=20, consumer responsive -> rfd_in_1 falls at the grant edge, then data_out=60, tag_out=0, dav_out_ low exactly 2 edges after grant.
- Both channels request together after reset (ch1 3,4; ch2 100,200) -> first output 14/tag 0, second 600/tag 1; rfd_in_2 stays 1 until its own grant.
- Max operands base=255, height=255 -> data_out=1020 with no truncation.
- Consumer holds rfd_out=0 for 5 cycles in S_OUT -> dav_out_ stays 1 and STAR stays S_OUT; dav_out_ falls one edge after rfd_out rises.
- reset asserted in S_ACK with dav_out_=0 -> next edge dav_out_=1, rfd_in_1=rfd_in_2=1, data_out=0; a subsequent dual request grants ch1.
- With PERIMETER_ARB_STATS_EN defined, 3 grants ch1 and 2 grants ch2 -> served_1=3, served_2=2; served_1 preset near 16'hFFFF wraps to 0 on the next grant.
